// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destinations and issues EX forward selects and ID stalls.
// Define FWD_ZERO_REG_EN to hardwire register 0 (never tracked, never matched).
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 3,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr_en,
    input  logic                  id_is_load,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b,
    output logic                  ex_bubble,
    output logic [15:0]           stall_cnt
);

`ifdef FWD_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } trk_t;

    trk_t [FWD_DEPTH-1:0] trk_q, trk_d;
    logic [FWD_DEPTH-1:0] match_a, match_b;
    logic [SEL_W-1:0]     sel_a, sel_b;
    logic [SEL_W-1:0]     fwd_sel_a_q, fwd_sel_a_d, fwd_sel_b_q, fwd_sel_b_d;
    logic                 ex_bubble_q, ex_bubble_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic                 stall_c;
    logic                 src_ok_a, src_ok_b, dst_ok;

    assign src_ok_a = !(ZERO_REG_EN && (id_rs1 == '0));
    assign src_ok_b = !(ZERO_REG_EN && (id_rs2 == '0));
    assign dst_ok   = !(ZERO_REG_EN && (id_rd == '0));

    // Source match, youngest-wins priority select and load-use stall detection.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        match_a = '0;
        match_b = '0;
        sel_a   = '0;
        sel_b   = '0;
        stall_c = 1'b0;
        for (int i = 0; i < FWD_DEPTH; i++) begin
            match_a[i] = id_valid & trk_q[i].valid & (trk_q[i].rd == id_rs1) & src_ok_a;
            match_b[i] = id_valid & trk_q[i].valid & (trk_q[i].rd == id_rs2) & src_ok_b;
        end
        // Walk oldest to youngest so the youngest match overwrites.
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (match_a[i]) sel_a = SEL_W'(i + 1);
            if (match_b[i]) sel_b = SEL_W'(i + 1);
        end
        for (int j = 0; j < FWD_DEPTH; j++) begin
            if ((j < LOAD_LAT) && trk_q[j].is_load && (match_a[j] || match_b[j])) stall_c = 1'b1;
        end
    end

    assign stall = stall_c;

    always_comb begin
        trk_d = '0;
        if (!stall_c && !flush) begin
            trk_d[0].valid   = id_valid & id_wr_en & dst_ok;
            trk_d[0].rd      = id_rd;
            trk_d[0].is_load = id_is_load;
        end
        for (int i = 1; i < FWD_DEPTH; i++) begin
            trk_d[i] = trk_q[i-1];
            if (flush) trk_d[i].valid = 1'b0;
        end

        if (flush || stall_c) begin
            fwd_sel_a_d = '0;
            fwd_sel_b_d = '0;
            ex_bubble_d = 1'b1;
        end else begin
            fwd_sel_a_d = sel_a;
            fwd_sel_b_d = sel_b;
            ex_bubble_d = ~id_valid;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_c && !flush && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_q       <= '0;
            fwd_sel_a_q <= '0;
            fwd_sel_b_q <= '0;
            ex_bubble_q <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            trk_q       <= trk_d;
            fwd_sel_a_q <= fwd_sel_a_d;
            fwd_sel_b_q <= fwd_sel_b_d;
            ex_bubble_q <= ex_bubble_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel_a = fwd_sel_a_q;
    assign fwd_sel_b = fwd_sel_b_q;
    assign ex_bubble = ex_bubble_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (default parameters): vector table plus scoreboard queue.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        id_wr_en, id_is_load;
    logic        stall;
    logic [2:0]  fwd_sel_a, fwd_sel_b;
    logic        ex_bubble;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FWD_ZERO_REG_EN
    localparam logic [2:0] ZEXP = 3'd0;
`else
    localparam logic [2:0] ZEXP = 3'd1;
`endif

    fwd_hazard_unit #(.REG_ADDR_W(3), .FWD_DEPTH(2), .LOAD_LAT(1), .SEL_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_wr_en   (id_wr_en),
        .id_is_load (id_is_load),
        .stall      (stall),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .ex_bubble  (ex_bubble),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        v;
        logic [2:0]  rs1, rs2, rd;
        logic        we, ld;
        logic        e_stall;
        logic [2:0]  e_a, e_b;
        logic        e_bub;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic [2:0]  a, b;
        logic        bub;
        logic [15:0] cnt;
        logic [7:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[19];

    function automatic vec_t mk(input logic fl, v, input logic [2:0] rs1, rs2, rd, input logic we, ld,
                                input logic e_stall, input logic [2:0] e_a, e_b, input logic e_bub,
                                input logic [15:0] e_cnt);
        vec_t r;
        r = '{fl, v, rs1, rs2, rd, we, ld, e_stall, e_a, e_b, e_bub, e_cnt};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        flush      = t.fl;
        id_valid   = t.v;
        id_rs1     = t.rs1;
        id_rs2     = t.rs2;
        id_rd      = t.rd;
        id_wr_en   = t.we;
        id_is_load = t.ld;
    endtask

    task automatic pop_and_compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d_sel_a", e.idx), 32'(fwd_sel_a), 32'(e.a));
            check($sformatf("v%0d_sel_b", e.idx), 32'(fwd_sel_b), 32'(e.b));
            check($sformatf("v%0d_bubble", e.idx), 32'(ex_bubble), 32'(e.bub));
            check($sformatf("v%0d_stall_cnt", e.idx), 32'(stall_cnt), 32'(e.cnt));
        end
    endtask

    initial begin
        //           fl v  rs1 rs2 rd we ld  stall a  b  bub cnt
        vecs[0]  = mk(0, 1, 1,  2,  7, 0, 0,  0,   0, 0, 0,  0); // empty tracker
        vecs[1]  = mk(0, 1, 6,  6,  3, 1, 0,  0,   0, 0, 0,  0); // write r3
        vecs[2]  = mk(0, 1, 3,  1,  0, 0, 0,  0,   1, 0, 0,  0); // read r3 next -> 1
        vecs[3]  = mk(0, 1, 0,  0,  3, 1, 0,  0,   0, 0, 0,  0); // write r3
        vecs[4]  = mk(0, 1, 1,  2,  0, 0, 0,  0,   0, 0, 0,  0); // independent
        vecs[5]  = mk(0, 1, 3,  2,  0, 0, 0,  0,   2, 0, 0,  0); // read r3 two later -> 2
        vecs[6]  = mk(0, 1, 1,  2,  5, 1, 0,  0,   0, 0, 0,  0); // write r5
        vecs[7]  = mk(0, 1, 1,  2,  5, 1, 0,  0,   0, 0, 0,  0); // write r5 again
        vecs[8]  = mk(0, 1, 5,  5,  0, 0, 0,  0,   1, 1, 0,  0); // youngest wins on both
        vecs[9]  = mk(0, 0, 5,  5,  0, 0, 0,  0,   0, 0, 1,  0); // id bubble
        vecs[10] = mk(0, 1, 1,  2,  4, 1, 1,  0,   0, 0, 0,  0); // load r4
        vecs[11] = mk(0, 1, 1,  4,  6, 1, 0,  1,   0, 0, 1,  1); // load-use stall
        vecs[12] = mk(0, 1, 1,  4,  6, 1, 0,  0,   0, 2, 0,  1); // replay -> sel_b 2
        vecs[13] = mk(0, 1, 6,  4,  0, 0, 0,  0,   1, 0, 0,  1); // r4 aged out
        vecs[14] = mk(0, 1, 0,  0,  2, 1, 1,  0,   0, 0, 0,  1); // load r2
        vecs[15] = mk(1, 1, 2,  0,  0, 0, 0,  1,   0, 0, 1,  1); // flush during stall
        vecs[16] = mk(0, 1, 2,  0,  0, 0, 0,  0,   0, 0, 0,  1); // tracker empty after flush
        vecs[17] = mk(0, 1, 1,  1,  0, 1, 0,  0,   0, 0, 0,  1); // write r0
        vecs[18] = mk(0, 1, 0,  1,  0, 0, 0,  0,   ZEXP, 0, 0, 1); // read r0

        reset = 1'b1;
        drive('0);
        #2;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_sel_a", 32'(fwd_sel_a), 32'd0);
        check("reset_sel_b", 32'(fwd_sel_b), 32'd0);
        check("reset_bubble", 32'(ex_bubble), 32'd1);
        check("reset_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            exp_t e;
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            e = '{vecs[i].e_a, vecs[i].e_b, vecs[i].e_bub, vecs[i].e_cnt, 8'(i)};
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            pop_and_compare();
        end

        // Async reset in the middle of a load-use stall.
        @(negedge clk);
        drive(mk(0, 1, 1, 2, 4, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_stall", 32'(stall), 32'd0);
        check("async_reset_bubble", 32'(ex_bubble), 32'd1);
        check("async_reset_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        check("held_reset_sel_a", 32'(fwd_sel_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("post_reset_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("post_reset_bubble", 32'(ex_bubble), 32'd0);
        check("post_reset_sel_a", 32'(fwd_sel_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
